// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared types and default sizing for the FIFO write-port arbiter.
//   Contents: arbiter state enum and default FIFO_WIDTH / NUM_REQ / MAX_BURST.
package fifo_wr_arbiter_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the producer request bus and the FIFO write port.
//   master : producers / FIFO side (drives req, req_data, fifo_full)
//   slave  : arbiter side (drives gnt, grant_id, wr_en, data_in, busy)
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [IDW-1:0]                grant_id;
  logic                          fifo_full;
  logic                          wr_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, grant_id, wr_en, data_in, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, grant_id, wr_en, data_in, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// rr_arb_pick
//   Combinational round-robin selector. Searches req & mask starting at
//   last_ptr+1 (mod NUM_REQ) and returns the first hit.
//   Ports: req, mask, last_ptr in; pick (one-hot), pick_idx, any out.
module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDW-1:0]     last_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDW-1:0]     pick_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] masked;
  int                 idx;

  always_comb begin
    masked   = req & mask;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    // k runs 1..NUM_REQ so the last-granted index is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_ptr) + k) % NUM_REQ;
      if (!any && masked[idx]) begin
        any           = 1'b1;
        pick[idx]     = 1'b1;
        pick_idx      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between NUM_REQ
//   producers, with at most MAX_BURST words per grant. Never writes while
//   fifo_full is high.
//   Ports: clk, rst_n (async, active-low); bus (slave modport):
//     req/req_data/fifo_full in; gnt/grant_id/busy registered out;
//     wr_en/data_in combinational out.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ARB_IDLE  | no grant held, waiting for any req
//   ARB_GRANT | gnt/grant_id valid, words transfer when not full
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_ptr_q, last_ptr_d;
  logic [CW-1:0]      burst_cnt_q, burst_cnt_d;

  logic               xfer;
  logic               release_c;
  logic [NUM_REQ-1:0] pick_mask;
  logic [IDW-1:0]     search_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [FIFO_WIDTH-1:0] data_mux;

  assign xfer      = gnt_q[grant_id_q] & bus.req[grant_id_q] & ~bus.fifo_full;
  assign release_c = (state_q == ARB_GRANT) &
                     (~bus.req[grant_id_q] | (xfer & (burst_cnt_q == BURST_LAST)));

  // While granted the search rotates from the current holder; last_ptr_q
  // only catches up on release, so it is the right start point in IDLE.
  assign search_ptr = (state_q == ARB_GRANT) ? grant_id_q : last_ptr_q;
  // A holder that dropped req is excluded from the same-cycle re-arbitration.
  assign pick_mask  = ~(gnt_q & ~bus.req);

  rr_arb_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req      (bus.req),
    .mask     (pick_mask),
    .last_ptr (search_ptr),
    .pick     (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    grant_id_d  = grant_id_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_GRANT;
          gnt_d       = pick_oh;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (release_c) begin
          last_ptr_d  = grant_id_q;
          burst_cnt_d = '0;
          if (pick_any) begin
            gnt_d      = pick_oh;
            grant_id_d = pick_idx;
          end else begin
            state_d    = ARB_IDLE;
            gnt_d      = '0;
            grant_id_d = '0;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      grant_id_q  <= '0;
      last_ptr_q  <= IDW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      grant_id_q  <= grant_id_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) data_mux = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  assign bus.wr_en    = xfer;
  assign bus.data_in  = (|gnt_q) ? data_mux : '0;
  assign bus.gnt      = gnt_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fifo_wr_arbiter_if #(.FIFO_WIDTH(W), .NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.data_in !== 16'h0) begin failures++; $display("FAIL reset_data_in got=%h exp=0000", bus.data_in); end
  endtask

  task automatic test_single_producer();
    apply_reset();
    bus.req = 4'b0001;
    bus.req_data[0 +: W] = 16'd0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_pre_gnt got=%b exp=0000", bus.gnt); end
    tick();
    for (int w = 0; w < 6; w++) begin
      bus.req_data[0 +: W] = W'(w);
      #1;
      checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt w=%0d got=%b exp=0001", w, bus.gnt); end
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en w=%0d got=%b exp=1", w, bus.wr_en); end
      checks++; if (bus.data_in !== W'(w)) begin failures++; $display("FAIL single_data w=%0d got=%h exp=%h", w, bus.data_in, W'(w)); end
      tick();
    end
    bus.req = 4'b0000;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL single_drop_wr_en got=%b exp=0", bus.wr_en); end
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_idle_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    int           exp_id;
    apply_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'(16'h1000 * (i + 1));
    tick();
    for (int c = 0; c < 20; c++) begin
      exp_id  = (c / MB) % N;
      exp_gnt = N'(1) << exp_id;
      #1;
      checks++; if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt); end
      checks++; if (bus.grant_id !== 2'(exp_id)) begin failures++; $display("FAIL rr_grant_id c=%0d got=%0d exp=%0d", c, bus.grant_id, exp_id); end
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_en c=%0d got=%b exp=1", c, bus.wr_en); end
      checks++; if (bus.data_in !== W'(16'h1000 * (exp_id + 1))) begin failures++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, bus.data_in, W'(16'h1000 * (exp_id + 1))); end
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_fifo_full();
    apply_reset();
    bus.req = 4'b0100;
    bus.req_data[2*W +: W] = 16'h2200;
    tick();
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL full_gnt got=%b exp=0100", bus.gnt); end
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h2200) begin failures++; $display("FAIL full_w0 got=%b/%h exp=1/2200", bus.wr_en, bus.data_in); end
    tick();
    bus.req_data[2*W +: W] = 16'h2201;
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h2201) begin failures++; $display("FAIL full_w1 got=%b/%h exp=1/2201", bus.wr_en, bus.data_in); end
    tick();
    bus.req_data[2*W +: W] = 16'h2202;
    bus.req = 4'b1100;
    bus.req_data[3*W +: W] = 16'h3300;
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL full_hold_wr_en c=%0d got=%b exp=0", c, bus.wr_en); end
      checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL full_hold_gnt c=%0d got=%b exp=0100", c, bus.gnt); end
      tick();
    end
    bus.fifo_full = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h2202) begin failures++; $display("FAIL full_w2 got=%b/%h exp=1/2202", bus.wr_en, bus.data_in); end
    tick();
    bus.req_data[2*W +: W] = 16'h2203;
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h2203) begin failures++; $display("FAIL full_w3 got=%b/%h exp=1/2203", bus.wr_en, bus.data_in); end
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL full_rotate_gnt got=%b exp=1000", bus.gnt); end
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h3300) begin failures++; $display("FAIL full_rotate_w got=%b/%h exp=1/3300", bus.wr_en, bus.data_in); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_early_drop();
    apply_reset();
    bus.req = 4'b0010;
    bus.req_data[1*W +: W] = 16'h1100;
    bus.req_data[3*W +: W] = 16'h3300;
    tick();
    bus.req = 4'b1010;
    #1;
    checks++; if (bus.gnt !== 4'b0010 || bus.wr_en !== 1'b1) begin failures++; $display("FAIL drop_first got=%b/%b exp=0010/1", bus.gnt, bus.wr_en); end
    tick();
    bus.req = 4'b1001;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL drop_wr_en got=%b exp=0", bus.wr_en); end
    tick();
    for (int k = 0; k < MB; k++) begin
      #1;
      checks++; if (bus.gnt !== 4'b1000 || bus.wr_en !== 1'b1) begin failures++; $display("FAIL drop_p3 k=%0d got=%b/%b exp=1000/1", k, bus.gnt, bus.wr_en); end
      tick();
    end
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL drop_next_gnt got=%b exp=0001", bus.gnt); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.req = 4'b1000;
    bus.req_data[3*W +: W] = 16'h3333;
    tick();
    #1;
    checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL rstmid_pre_wr_en got=%b exp=1", bus.wr_en); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rstmid_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.data_in !== 16'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0000", bus.data_in); end
    bus.req = 4'b1001;
    bus.req_data[0 +: W] = 16'h0A0A;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rstmid_held_gnt got=%b exp=0000", bus.gnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_restart_gnt got=%b exp=0001", bus.gnt); end
    checks++; if (bus.wr_en !== 1'b1 || bus.data_in !== 16'h0A0A) begin failures++; $display("FAIL rstmid_restart_w got=%b/%h exp=1/0a0a", bus.wr_en, bus.data_in); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] served;
    logic [N-1:0] xfer_last;
    int           wait_cnt [N];
    int           gi;
    int           max_wait;
    max_wait = (N - 1) * MB;
    apply_reset();
    served = '0;
    xfer_last = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 32768; cyc++) begin
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1;
            served[i] = 1'b0;
            bus.req_data[i*W +: W] = W'($urandom);
          end
        end else if (served[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b0;
          wait_cnt[i] = 0;
        end else if (xfer_last[i]) begin
          bus.req_data[i*W +: W] = W'($urandom);
        end
      end
      #1;
      xfer_last = '0;
      gi = 0;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) gi = i;
      checks++; if (bus.wr_en && bus.fifo_full) begin failures++; $display("FAIL rnd_write_when_full cyc=%0d got=1 exp=0", cyc); end
      checks++; if (!$onehot0(bus.gnt)) begin failures++; $display("FAIL rnd_onehot cyc=%0d got=%b exp=onehot0", cyc, bus.gnt); end
      checks++; if (bus.grant_id !== 2'(gi)) begin failures++; $display("FAIL rnd_grant_id cyc=%0d got=%0d exp=%0d", cyc, bus.grant_id, gi); end
      if (bus.wr_en) begin
        checks++; if (bus.data_in !== bus.req_data[gi*W +: W] || !bus.req[gi]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, bus.data_in, bus.req_data[gi*W +: W]); end
        xfer_last[gi] = 1'b1;
        served[gi] = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (i == gi) wait_cnt[i] = 0;
          else if (bus.req[i] && !served[i]) wait_cnt[i]++;
        end
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (wait_cnt[i] > max_wait) begin failures++; $display("FAIL rnd_starve p=%0d cyc=%0d got=%0d exp<=%0d", i, cyc, wait_cnt[i], max_wait); wait_cnt[i] = 0; end
      end
      tick();
    end
    bus.req = '0;
    bus.fifo_full = 1'b0;
    tick();
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    test_reset();
    test_single_producer();
    test_round_robin();
    test_fifo_full();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
